nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameter ACC_W, default 16: phase accumulator width; SHALL be >= 12.
REQ-002 Parameter FTW_W, default 8: tuning word, step, dwell and config data width.
REQ-003 Clock is one clock; reset is asynchronous and active-high; ports SHALL be named clk and rst.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cfg_we  in  1  config write strobe.
REQ-007 cfg_addr  in  2  register select: 0 start_ftw, 1 stop_ftw, 2 step, 3 dwell.
REQ-008 cfg_data  in  FTW_W  config write data.
REQ-009 start  in  1  begin sweep request.
REQ-010 abort  in  1  terminate sweep.
REQ-011 phase  out  8  registered phase for the sine lookup, equal to acc[ACC_W-1:ACC_W-8].
REQ-012 phase_vld  out  1  phase is live sweep data.
REQ-013 cur_ftw  out  FTW_W  current tuning word.
REQ-014 busy  out  1  high in RUN.
REQ-015 done  out  1  one-cycle pulse at sweep completion.

Function
REQ-016 FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE: start=1 and abort=0 -> RUN next cycle; acc<=0, cur_ftw<=start_ftw, dwell_cnt<=0.
REQ-018 RUN, each cycle: phase_vld=1; phase reflects acc before the add; acc <= acc + ({cur_ftw,4'b0} zero-extended), wrapping modulo 2^ACC_W.
REQ-019 RUN: dwell_cnt increments each cycle; each cur_ftw value SHALL be held exactly dwell+1 cycles (dwell=0 -> 1 cycle).
REQ-020 At dwell expiry with cur_ftw != stop_ftw: cur_ftw moves by step toward stop_ftw (up if stop>start, down otherwise), clamped to stop_ftw; no overflow or underflow.
REQ-021 At dwell expiry with cur_ftw == stop_ftw, or with step == 0: sweep finishes (RUN -> DONE).
REQ-022 DONE lasts one cycle: done=1, busy=0, phase_vld=0, then IDLE.
REQ-023 abort SHALL take priority over all other inputs: in any state, next state IDLE; no done pulse; phase and cur_ftw hold their values.
REQ-024 start in RUN or DONE SHALL be ignored.
REQ-025 cfg_we writes SHALL be applied only in IDLE; writes in RUN or DONE are dropped. start_ftw and stop_ftw are sampled at start acceptance.
REQ-026 start and cfg_we in the same IDLE cycle: the write updates the register and the sweep uses the pre-write value.

Reset
REQ-027 rst SHALL force IDLE, acc=0, dwell_cnt=0, all config registers 0, phase=0, cur_ftw=0, phase_vld=0, busy=0 and done=0, asynchronously and mid-sweep.

Configuration
REQ-028 With SWEEP_LOOP_EN defined, REQ-021 SHALL instead reload cur_ftw<=start_ftw and dwell_cnt<=0, and stay in RUN with acc not cleared; done never pulses; the sweep exits only via abort or rst.
REQ-029 Without SWEEP_LOOP_EN, the block SHALL run single sweeps as in REQ-021 and REQ-022.

Structure
REQ-030 Shared package nco_pkg SHALL hold the FSM state enum, config address constants, and the default widths.
REQ-031 Sub-module nco_sweep_step (combinational next-ftw: direction, clamp, finish flag) is natural and SHALL be used.

Verification
REQ-032 start=1, stop=4, step=1, dwell=2, then pulse start -> cur_ftw sequence 1,1,1,2,2,2,3,3,3,4,4,4 across 12 phase_vld cycles; done pulses on the 13th cycle.
REQ-033 start=1, stop=6, step=2, dwell=0 -> cur_ftw 1,3,5,6; then one done pulse.
REQ-034 start=10, stop=4, step=3, dwell=0 -> cur_ftw 10,7,4; start=16, stop=16, step=5, dwell=3 -> 4 cycles at 16 with phase 0,1,2,3, then done.
REQ-035 abort on the 3rd RUN cycle -> IDLE next cycle; phase_vld=0 and done=0; a cfg_we issued during RUN leaves its register unchanged.
REQ-036 rst asserted mid-sweep -> all outputs 0 immediately, without waiting for a clk edge.
REQ-037 With SWEEP_LOOP_EN and start=1, stop=2, step=1, dwell=0 -> cur_ftw 1,2,1,2,... for 8 cycles, with no done pulse; phase continuity is preserved across the reload.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep controller: FSM state encoding,
// config register addresses and default widths.
package nco_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int FTW_W_DEF = 8;

  localparam logic [1:0] CFG_START_FTW = 2'd0;
  localparam logic [1:0] CFG_STOP_FTW  = 2'd1;
  localparam logic [1:0] CFG_STEP      = 2'd2;
  localparam logic [1:0] CFG_DWELL     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nco_sweep_step.sv
// Next tuning word for a frequency sweep: moves the current word one step
// toward the stop word, clamped so it lands exactly on stop without
// overflow or underflow. o_finish flags that the sweep has nothing left to do.
module nco_sweep_step #(
  parameter int FTW_W = 8
) (
  input  logic [FTW_W-1:0] i_cur_ftw,
  input  logic [FTW_W-1:0] i_start_ftw,
  input  logic [FTW_W-1:0] i_stop_ftw,
  input  logic [FTW_W-1:0] i_step,
  output logic [FTW_W-1:0] o_next_ftw,
  output logic             o_finish
);

  logic             w_up;
  logic [FTW_W-1:0] w_gap;

  // Direction is fixed by the sweep endpoints; the current word never
  // passes stop, so the gap below is always non-negative.
  assign w_up  = i_stop_ftw > i_start_ftw;
  assign w_gap = w_up ? (i_stop_ftw - i_cur_ftw) : (i_cur_ftw - i_stop_ftw);

  // Comparing the remaining gap against the step avoids computing a sum or
  // difference that could wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    o_next_ftw = i_stop_ftw;
    if (w_gap > i_step) begin
      o_next_ftw = w_up ? (i_cur_ftw + i_step) : (i_cur_ftw - i_step);
    end
  end

  assign o_finish = (i_cur_ftw == i_stop_ftw) || (i_step == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// NCO frequency sweep controller. Steps a tuning word from start_ftw to
// stop_ftw, holding each word for dwell+1 cycles, and drives a phase
// accumulator whose top 8 bits address a sine lookup.
// Build option: define SWEEP_LOOP_EN to sweep continuously (reload
// start_ftw at the end, never pulse done; exit only via abort or rst).
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int FTW_W = FTW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [FTW_W-1:0] cfg_data,
  input  logic             start,
  input  logic             abort,
  output logic [7:0]       phase,
  output logic             phase_vld,
  output logic [FTW_W-1:0] cur_ftw,
  output logic             busy,
  output logic             done
);

  if (ACC_W < 12) begin : g_acc_w_chk
    $error("nco_sweep_ctrl: ACC_W must be at least 12");
  end

  state_t r_state;
  state_t w_state_nxt;

  // Software-visible config registers.
  logic [FTW_W-1:0] r_start_ftw, r_stop_ftw, r_step, r_dwell;
  // Copies taken when a sweep is accepted, so later writes cannot disturb it.
  logic [FTW_W-1:0] r_run_start, r_run_stop, r_run_step, r_run_dwell;

  logic [ACC_W-1:0] r_acc;
  logic [FTW_W-1:0] r_cur_ftw;
  logic [FTW_W-1:0] r_dwell_cnt;

  logic [ACC_W-1:0] w_inc;
  logic [FTW_W-1:0] w_next_ftw;
  logic             w_finish;
  logic             w_expire;

  assign w_inc    = ACC_W'({r_cur_ftw, 4'b0000});
  assign w_expire = (r_dwell_cnt == r_run_dwell);

  nco_sweep_step #(.FTW_W(FTW_W)) u_step (
    .i_cur_ftw   (r_cur_ftw),
    .i_start_ftw (r_run_start),
    .i_stop_ftw  (r_run_stop),
    .i_step      (r_run_step),
    .o_next_ftw  (w_next_ftw),
    .o_finish    (w_finish)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs; abort wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    phase_vld   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        phase_vld = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_expire && w_finish) begin
`ifdef SWEEP_LOOP_EN
          w_state_nxt = S_RUN;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config register writes, accepted only while idle and not aborting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_ftw <= '0;
      r_stop_ftw  <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
    end else if (r_state == S_IDLE && cfg_we && !abort) begin
      case (cfg_addr)
        CFG_START_FTW: r_start_ftw <= cfg_data;
        CFG_STOP_FTW:  r_stop_ftw  <= cfg_data;
        CFG_STEP:      r_step      <= cfg_data;
        default:       r_dwell     <= cfg_data;
      endcase
    end
  end

  // Sweep datapath: latch the sweep on start, then accumulate phase and
  // advance the tuning word at each dwell expiry. Abort freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cur_ftw   <= '0;
      r_dwell_cnt <= '0;
      r_run_start <= '0;
      r_run_stop  <= '0;
      r_run_step  <= '0;
      r_run_dwell <= '0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc       <= '0;
            r_cur_ftw   <= r_start_ftw;
            r_dwell_cnt <= '0;
            r_run_start <= r_start_ftw;
            r_run_stop  <= r_stop_ftw;
            r_run_step  <= r_step;
            r_run_dwell <= r_dwell;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_inc;
          if (!w_expire) begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
          end else if (!w_finish) begin
            r_cur_ftw   <= w_next_ftw;
            r_dwell_cnt <= '0;
          end else begin
`ifdef SWEEP_LOOP_EN
            r_cur_ftw   <= r_run_start;
            r_dwell_cnt <= '0;
`else
            r_cur_ftw   <= r_cur_ftw;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign phase   = r_acc[ACC_W-1 -: 8];
  assign cur_ftw = r_cur_ftw;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl. A reference model plans each sweep
// as a list of per-cycle tuning words and tracks the phase as a running sum;
// every cycle all outputs are compared against it. Directed sweeps, abort,
// async reset and a randomized stretch follow.
module tb_nco_sweep_ctrl;

  localparam int ACC_W = 16;
  localparam int FTW_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_addr = '0;
  logic [FTW_W-1:0] cfg_data = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [7:0]       phase;
  logic             phase_vld;
  logic [FTW_W-1:0] cur_ftw;
  logic             busy;
  logic             done;

  nco_sweep_ctrl #(.ACC_W(ACC_W), .FTW_W(FTW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .start     (start),
    .abort     (abort),
    .phase     (phase),
    .phase_vld (phase_vld),
    .cur_ftw   (cur_ftw),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_cfg[4];
  int     m_plan[$];
  int     m_idx;
  int     m_acc;
  int     m_cur;

  // Observations collected while phase_vld is high.
  int obs_ftw[$];
  int obs_phase[$];
  int done_cnt;
  int done_at;

  function automatic void build_plan(int s, int e, int st, int dw);
    int v = s;
    m_plan.delete();
    while (1) begin
      for (int k = 0; k <= dw; k++) m_plan.push_back(v);
      if (v == e || st == 0) break;
      if (e > s) v = (v + st > e) ? e : v + st;
      else       v = (v - st < e) ? e : v - st;
    end
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_acc  = 0;
    m_cur  = 0;
    m_idx  = 0;
    for (int k = 0; k < 4; k++) m_cfg[k] = 0;
    m_plan.delete();
  endfunction

  function automatic void model_step();
    if (abort) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            build_plan(m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]);
            m_idx  = 0;
            m_acc  = 0;
            m_cur  = m_plan[0];
            m_mode = M_RUN;
          end
          if (cfg_we) m_cfg[cfg_addr] = int'(cfg_data);
        end
        M_RUN: begin
          m_acc = (m_acc + 16 * m_plan[m_idx]) % (1 << ACC_W);
          m_idx++;
          if (m_idx == m_plan.size()) begin
`ifdef SWEEP_LOOP_EN
            m_idx = 0;
            m_cur = m_plan[0];
`else
            m_mode = M_DONE;
`endif
          end else begin
            m_cur = m_plan[m_idx];
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    check("busy",      busy,      m_mode == M_RUN);
    check("phase_vld", phase_vld, m_mode == M_RUN);
    check("done",      done,      m_mode == M_DONE);
    check("cur_ftw",   cur_ftw,   m_cur);
    check("phase",     phase,     (m_acc >> (ACC_W - 8)) & 255);
    if (phase_vld) begin
      obs_ftw.push_back(int'(cur_ftw));
      obs_phase.push_back(int'(phase));
    end
    if (done) begin
      done_cnt++;
      done_at = obs_ftw.size();
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input int d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = FTW_W'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic setup(input int s, input int e, input int st, input int dw);
    cfg_write(2'd0, s);
    cfg_write(2'd1, e);
    cfg_write(2'd2, st);
    cfg_write(2'd3, dw);
  endtask

  task automatic clear_obs();
    obs_ftw.delete();
    obs_phase.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  task automatic finish_sweep(input int max_cyc);
    for (int i = 0; i < max_cyc && m_mode != M_IDLE; i++) cycle();
    check("sweep_end_busy", busy, 0);
  endtask

  task automatic run_sweep(input int max_cyc);
    clear_obs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    finish_sweep(max_cyc);
  endtask

  function automatic int obs_at(int i);
    return (obs_ftw.size() > i) ? obs_ftw[i] : -1;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_phase"},   phase,     0);
    check({tag, "_vld"},     phase_vld, 0);
    check({tag, "_cur_ftw"}, cur_ftw,   0);
    check({tag, "_busy"},    busy,      0);
    check({tag, "_done"},    done,      0);
  endtask

  int exp_a[12] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4};
  int exp_b[4]  = '{1, 3, 5, 6};
  int exp_c[3]  = '{10, 7, 4};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    clear_obs();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    cycle();

`ifndef SWEEP_LOOP_EN
    // Up-sweep with dwell 2: each word held three cycles.
    setup(1, 4, 1, 2);
    run_sweep(200);
    check("a_len", obs_ftw.size(), 12);
    for (int i = 0; i < 12; i++) check("a_ftw", obs_at(i), exp_a[i]);
    check("a_done_cnt", done_cnt, 1);
    check("a_done_at", done_at, 12);

    // Step overshoots stop: clamp to 6.
    setup(1, 6, 2, 0);
    run_sweep(200);
    check("b_len", obs_ftw.size(), 4);
    for (int i = 0; i < 4; i++) check("b_ftw", obs_at(i), exp_b[i]);
    check("b_done_cnt", done_cnt, 1);

    // Down-sweep.
    setup(10, 4, 3, 0);
    run_sweep(200);
    check("c_len", obs_ftw.size(), 3);
    for (int i = 0; i < 3; i++) check("c_ftw", obs_at(i), exp_c[i]);
    check("c_done_cnt", done_cnt, 1);

    // start == stop: one word for dwell+1 cycles, phase advancing by one.
    setup(16, 16, 5, 3);
    run_sweep(200);
    check("d_len", obs_ftw.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("d_ftw", obs_at(i), 16);
      check("d_phase", (obs_phase.size() > i) ? obs_phase[i] : -1, i);
    end
    check("d_done_cnt", done_cnt, 1);

    // Write and start together: the sweep uses the old start word.
    setup(3, 3, 0, 0);
    clear_obs();
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd5;
    cycle();
    start = 1'b0; cfg_we = 1'b0;
    finish_sweep(50);
    check("e_first_old", obs_at(0), 3);
    run_sweep(50);
    check("e_first_new", obs_at(0), 5);

    // Abort on the third RUN cycle; a write during RUN must be dropped.
    setup(1, 200, 1, 0);
    clear_obs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd99;
    cycle();
    cfg_we = 1'b0;
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_vld",  phase_vld, 0);
    check("abort_done", done,      0);
    check("abort_busy", busy,      0);
    check("abort_hold_ftw", cur_ftw, 3);
    cycle();
    cycle();
    check("abort_no_done", done_cnt, 0);
    run_sweep(400);
    check("run_write_dropped", obs_at(0), 1);
`else
    // Continuous sweep: 1,2,1,2,... and never done.
    setup(1, 2, 1, 0);
    clear_obs();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("loop_len", obs_ftw.size(), 8);
    for (int i = 0; i < 8; i++) check("loop_ftw", obs_at(i), (i % 2) + 1);
    check("loop_no_done", done_cnt, 0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    cycle();
`endif

    // Asynchronous reset in the middle of a sweep.
    setup(1, 50, 1, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      abort    = ($urandom_range(0, 49) == 0);
      start    = ($urandom_range(0, 5) == 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_data = (cfg_addr == 2'd3) ? FTW_W'($urandom_range(0, 3))
                                    : FTW_W'($urandom_range(0, 255));
      cycle();
    end
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
